// File: rtl/int_wb_arbiter.sv
// Round-robin arbiter sharing two registered integer writeback ports among NUM_REQ units.
// Optional build macro WB_ARB_STALL_CNT_EN adds per-requester saturating stall counters.
module int_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PREG_W  = 6,
  parameter int ROBID_W = 7,
  parameter int DATA_W  = 64
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_need_to_wb,
  input  logic [NUM_REQ*PREG_W-1:0]  req_prd,
  input  logic [NUM_REQ*ROBID_W-1:0] req_robid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_result,
  output logic                       writeback0_valid,
  output logic                       writeback0_need_to_wb,
  output logic [PREG_W-1:0]          writeback0_prd,
  output logic [ROBID_W-1:0]         writeback0_robid,
  output logic [DATA_W-1:0]          writeback0_result,
  output logic                       writeback1_valid,
  output logic                       writeback1_need_to_wb,
  output logic [PREG_W-1:0]          writeback1_prd,
  output logic [ROBID_W-1:0]         writeback1_robid,
  output logic [DATA_W-1:0]          writeback1_result,
  input  logic                       flush_valid,
  input  logic [ROBID_W-1:0]         flush_robid
`ifdef WB_ARB_STALL_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0]      stall_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  function automatic logic younger(input logic [ROBID_W-1:0] a, input logic [ROBID_W-1:0] f);
    if (a[ROBID_W-1] == f[ROBID_W-1]) return a[ROBID_W-2:0] > f[ROBID_W-2:0];
    else return a[ROBID_W-2:0] < f[ROBID_W-2:0];
  endfunction

  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt, g0_idx, g1_idx, last_idx;
  logic               g0_valid, g1_valid;
  logic [NUM_REQ-1:0] squash, elig, grant;

  logic               g0_need, g1_need;
  logic [PREG_W-1:0]  g0_prd, g1_prd;
  logic [ROBID_W-1:0] g0_robid, g1_robid;
  logic [DATA_W-1:0]  g0_result, g1_result;

  logic               wb0_v_q, wb1_v_q, wb0_need_q, wb1_need_q;
  logic [PREG_W-1:0]  wb0_prd_q, wb1_prd_q;
  logic [ROBID_W-1:0] wb0_robid_q, wb1_robid_q;
  logic [DATA_W-1:0]  wb0_result_q, wb1_result_q;

  always_comb begin
    int idx;
    logic [PTR_W-1:0] pos;
    idx      = 0;
    pos      = '0;
    squash   = '0;
    grant    = '0;
    g0_valid = 1'b0;
    g1_valid = 1'b0;
    g0_idx   = '0;
    g1_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++)
      squash[i] = req_valid[i] && flush_valid &&
                  younger(req_robid[i*ROBID_W +: ROBID_W], flush_robid);
    elig = req_valid & ~squash;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      pos = PTR_W'(idx);
      if (elig[pos]) begin
        if (!g0_valid) begin
          g0_valid = 1'b1;
          g0_idx   = pos;
        end else if (!g1_valid) begin
          g1_valid = 1'b1;
          g1_idx   = pos;
        end
      end
    end
    if (g0_valid) grant[g0_idx] = 1'b1;
    if (g1_valid) grant[g1_idx] = 1'b1;
  end

  always_comb begin
    g0_need   = 1'b0;
    g1_need   = 1'b0;
    g0_prd    = '0;
    g1_prd    = '0;
    g0_robid  = '0;
    g1_robid  = '0;
    g0_result = '0;
    g1_result = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g0_idx == PTR_W'(i)) begin
        g0_need   = req_need_to_wb[i];
        g0_prd    = req_prd[i*PREG_W +: PREG_W];
        g0_robid  = req_robid[i*ROBID_W +: ROBID_W];
        g0_result = req_result[i*DATA_W +: DATA_W];
      end
      if (g1_idx == PTR_W'(i)) begin
        g1_need   = req_need_to_wb[i];
        g1_prd    = req_prd[i*PREG_W +: PREG_W];
        g1_robid  = req_robid[i*ROBID_W +: ROBID_W];
        g1_result = req_result[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    last_idx = g1_valid ? g1_idx : g0_idx;
    if (!g0_valid)                         rr_ptr_nxt = rr_ptr;
    else if (int'(last_idx) == NUM_REQ-1)  rr_ptr_nxt = '0;
    else                                   rr_ptr_nxt = last_idx + PTR_W'(1);
  end

  assign req_ready = reset_n ? (squash | grant) : '0;

  // Winners are already filtered against this cycle's flush, so a younger entry never loads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr       <= '0;
      wb0_v_q      <= 1'b0;
      wb0_need_q   <= 1'b0;
      wb0_prd_q    <= '0;
      wb0_robid_q  <= '0;
      wb0_result_q <= '0;
      wb1_v_q      <= 1'b0;
      wb1_need_q   <= 1'b0;
      wb1_prd_q    <= '0;
      wb1_robid_q  <= '0;
      wb1_result_q <= '0;
    end else begin
      rr_ptr  <= rr_ptr_nxt;
      wb0_v_q <= g0_valid;
      wb1_v_q <= g1_valid;
      if (g0_valid) begin
        wb0_need_q   <= g0_need;
        wb0_prd_q    <= g0_prd;
        wb0_robid_q  <= g0_robid;
        wb0_result_q <= g0_result;
      end
      if (g1_valid) begin
        wb1_need_q   <= g1_need;
        wb1_prd_q    <= g1_prd;
        wb1_robid_q  <= g1_robid;
        wb1_result_q <= g1_result;
      end
    end
  end

  assign writeback0_valid      = wb0_v_q && !(flush_valid && younger(wb0_robid_q, flush_robid));
  assign writeback0_need_to_wb = wb0_need_q;
  assign writeback0_prd        = wb0_prd_q;
  assign writeback0_robid      = wb0_robid_q;
  assign writeback0_result     = wb0_result_q;
  assign writeback1_valid      = wb1_v_q && !(flush_valid && younger(wb1_robid_q, flush_robid));
  assign writeback1_need_to_wb = wb1_need_q;
  assign writeback1_prd        = wb1_prd_q;
  assign writeback1_robid      = wb1_robid_q;
  assign writeback1_result     = wb1_result_q;

`ifdef WB_ARB_STALL_CNT_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stall
    logic [15:0] cnt_q;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                                        cnt_q <= '0;
      else if (req_valid[i] && !req_ready[i] && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
    assign stall_cnt[i*16 +: 16] = cnt_q;
  end
`endif

  a_distinct_ports: assert property (@(posedge clock) disable iff (!reset_n)
    g1_valid |-> (g0_valid && g0_idx != g1_idx));

endmodule

// File: tb/tb_int_wb_arbiter.sv
// Scoreboard bench for int_wb_arbiter: a behavioural model queues expected port contents.
module tb_int_wb_arbiter;
  localparam int N = 4, PW = 6, RW = 7, DW = 64;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic [N-1:0]    req_valid, req_ready, req_need_to_wb;
  logic [N*PW-1:0] req_prd;
  logic [N*RW-1:0] req_robid;
  logic [N*DW-1:0] req_result;
  logic            writeback0_valid, writeback0_need_to_wb, writeback1_valid, writeback1_need_to_wb;
  logic [PW-1:0]   writeback0_prd, writeback1_prd;
  logic [RW-1:0]   writeback0_robid, writeback1_robid;
  logic [DW-1:0]   writeback0_result, writeback1_result;
  logic            flush_valid;
  logic [RW-1:0]   flush_robid;
`ifdef WB_ARB_STALL_CNT_EN
  logic [N*16-1:0] stall_cnt;
`endif

  int_wb_arbiter #(.NUM_REQ(N), .PREG_W(PW), .ROBID_W(RW), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_need_to_wb(req_need_to_wb),
    .req_prd(req_prd), .req_robid(req_robid), .req_result(req_result),
    .writeback0_valid(writeback0_valid), .writeback0_need_to_wb(writeback0_need_to_wb),
    .writeback0_prd(writeback0_prd), .writeback0_robid(writeback0_robid),
    .writeback0_result(writeback0_result),
    .writeback1_valid(writeback1_valid), .writeback1_need_to_wb(writeback1_need_to_wb),
    .writeback1_prd(writeback1_prd), .writeback1_robid(writeback1_robid),
    .writeback1_result(writeback1_result),
    .flush_valid(flush_valid), .flush_robid(flush_robid)
`ifdef WB_ARB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic          v;
    logic          n;
    logic [PW-1:0] prd;
    logic [RW-1:0] rob;
    logic [DW-1:0] res;
  } wb_t;

  wb_t q0[$], q1[$];
  int errors = 0, checks = 0;
  logic [N-1:0]  want, persist;
  logic [RW-1:0] rob[N];
  int seq[N], stall_m[N];
  int mptr;
  bit rand_mode;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic young(input logic [RW-1:0] a, input logic [RW-1:0] f);
    if (a[RW-1] == f[RW-1]) return a[RW-2:0] > f[RW-2:0];
    return a[RW-2:0] < f[RW-2:0];
  endfunction

  function automatic wb_t entry(input int i);
    wb_t e;
    e.v   = 1'b1;
    e.n   = (seq[i] % 3) != 2;
    e.prd = PW'(i * 16 + seq[i] % 16);
    e.rob = rob[i];
    e.res = {32'(i + 1), 32'(seq[i] * 7 + 3)};
    return e;
  endfunction

  task automatic drive();
    wb_t e;
    for (int i = 0; i < N; i++) begin
      e = entry(i);
      req_valid[i]              = want[i];
      req_need_to_wb[i]         = e.n;
      req_prd[i*PW +: PW]       = e.prd;
      req_robid[i*RW +: RW]     = e.rob;
      req_result[i*DW +: DW]    = e.res;
    end
  endtask

  task automatic chk_port(input string p, input wb_t e, input logic v, input logic n,
                          input logic [PW-1:0] prd, input logic [RW-1:0] r, input logic [DW-1:0] res);
    chk({p, "_valid"}, v, e.v && !(flush_valid && young(e.rob, flush_robid)));
    if (e.v) begin
      chk({p, "_need"}, n, e.n);
      chk({p, "_prd"}, prd, e.prd);
      chk({p, "_robid"}, r, e.rob);
      chk({p, "_result"}, res, e.res);
    end
  endtask

  task automatic check_outputs();
    if (q0.size() != 1 || q1.size() != 1) begin
      chk("queue_depth", 64'(q0.size() + q1.size()), 64'd2);
      return;
    end
    chk_port("wb0", q0.pop_front(), writeback0_valid, writeback0_need_to_wb,
             writeback0_prd, writeback0_robid, writeback0_result);
    chk_port("wb1", q1.pop_front(), writeback1_valid, writeback1_need_to_wb,
             writeback1_prd, writeback1_robid, writeback1_result);
  endtask

  task automatic model_step();
    logic [N-1:0] sq, el, er;
    int g0, g1, i;
    wb_t e0, e1;
    chk("rr_ptr", 64'(dut.rr_ptr), 64'(mptr));
    for (int k = 0; k < N; k++) sq[k] = want[k] && flush_valid && young(rob[k], flush_robid);
    el = want & ~sq;
    g0 = -1;
    g1 = -1;
    for (int k = 0; k < N; k++) begin
      i = (mptr + k) % N;
      if (el[i]) begin
        if (g0 < 0) g0 = i;
        else if (g1 < 0) g1 = i;
      end
    end
    er = sq;
    e0 = '0;
    e1 = '0;
    if (g0 >= 0) begin er[g0] = 1'b1; e0 = entry(g0); end
    if (g1 >= 0) begin er[g1] = 1'b1; e1 = entry(g1); end
    chk("req_ready", req_ready, er);
    q0.push_back(e0);
    q1.push_back(e1);
    if (g1 >= 0) mptr = (g1 + 1) % N;
    else if (g0 >= 0) mptr = (g0 + 1) % N;
    for (int k = 0; k < N; k++) begin
      if (want[k] && !er[k] && stall_m[k] < 65535) stall_m[k]++;
      if (er[k]) begin
        seq[k]++;
        if (rand_mode) begin
          want[k] = 1'($urandom_range(0, 1));
          rob[k]  = RW'($urandom);
        end else begin
          want[k] = persist[k];
        end
      end
    end
  endtask

  task automatic run_cycle();
    drive();
    @(negedge clock);
    check_outputs();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    drive();
    reset_n = 1'b0;
    #1;
    chk("rst_ready", req_ready, '0);
    chk("rst_wb0_valid", writeback0_valid, 1'b0);
    chk("rst_wb1_valid", writeback1_valid, 1'b0);
    chk("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    q0.delete();
    q1.delete();
    q0.push_back('0);
    q1.push_back('0);
    mptr = 0;
    for (int k = 0; k < N; k++) stall_m[k] = 0;
  endtask

  task automatic drain();
    persist = '0;
    for (int c = 0; c < 8 && want != '0; c++) run_cycle();
    chk("drained", want, '0);
  endtask

  initial begin
    reset_n     = 1'b0;
    flush_valid = 1'b0;
    flush_robid = '0;
    rand_mode   = 1'b0;
    want        = '0;
    persist     = '0;
    mptr        = 0;
    for (int k = 0; k < N; k++) begin
      seq[k]     = 0;
      rob[k]     = RW'(k + 1);
      stall_m[k] = 0;
    end
    req_valid = '0; req_need_to_wb = '0; req_prd = '0; req_robid = '0; req_result = '0;
    @(posedge clock);
    #1;
    apply_reset();
    run_cycle();

    // all four continuously requesting
    want = 4'b1111; persist = 4'b1111;
    repeat (6) run_cycle();
    drain();

    // reset in the middle of traffic
    want = 4'b1111; persist = 4'b1111;
    run_cycle();
    apply_reset();
    repeat (2) run_cycle();
    drain();

    // lone requester 2 moves pointer to 3, then wins again from there
    want = 4'b0100; run_cycle();
    want = 4'b0100; run_cycle();
    run_cycle();

    // input squash
    rob[0] = 7'd12; rob[1] = 7'd5;
    want = 4'b0011; persist = '0;
    flush_valid = 1'b1; flush_robid = 7'd10;
    run_cycle();
    flush_valid = 1'b0;
    run_cycle();
    run_cycle();

    // output-register kill
    rob[2] = 7'd59; rob[3] = {1'b1, 6'd2};
    want = 4'b1100; persist = 4'b1100;
    run_cycle();
    flush_valid = 1'b1; flush_robid = 7'd60;
    run_cycle();
    flush_valid = 1'b0; persist = '0;
    run_cycle();
    drain();

    // random traffic with occasional flushes
    rand_mode = 1'b1;
    for (int c = 0; c < 80; c++) begin
      for (int k = 0; k < N; k++)
        if (!want[k] && $urandom_range(0, 2) == 0) begin
          want[k] = 1'b1;
          rob[k]  = RW'($urandom);
        end
      flush_valid = ($urandom_range(0, 5) == 0);
      flush_robid = RW'($urandom);
      run_cycle();
    end
    flush_valid = 1'b0;
    rand_mode = 1'b0;
    drain();
    run_cycle();

`ifdef WB_ARB_STALL_CNT_EN
    for (int k = 0; k < N; k++) chk("stall_cnt", 64'(stall_cnt[k*16 +: 16]), 64'(stall_m[k]));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
